// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serializer feeding a programmable 1..8-bit Moore pattern detector, with per-frame match count.
// Optional build macro SEQ_OVERLAP_EN: keep history/fill after a match so overlapping matches count.
module seq_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              CFG_WE,
  input  logic [7:0]        CFG_PAT,
  input  logic [2:0]        CFG_LEN,
  input  logic              IN_VALID,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic              X_OUT,
  output logic              Z,
  output logic [CNT_W-1:0]  MATCH_CNT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

`ifdef SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] word_q;
  logic              last_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        pat_q;
  logic [2:0]        len_q;
  logic [6:0]        hist_q;
  logic [3:0]        fill_q;
  logic              x_q;
  logic              z_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        hist_d;
  logic [3:0]        fill_inc;
  logic [3:0]        fill_d;
  logic [7:0]        len_mask;
  logic              hit;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  idx_dec;
  logic              handshake;

  assign IN_READY  = !R && ((state_q == S_IDLE) || (state_q == S_WAIT));
  assign handshake = IN_VALID && IN_READY;

  // Only the 7 most recent bits need storing; the 8th comes from the bit being shifted in.
  always_comb begin
    hist_d   = {hist_q, x_q};
    fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    len_mask = 8'hFF >> (3'd7 - len_q);
    hit      = (fill_inc > {1'b0, len_q}) && (((hist_d ^ pat_q) & len_mask) == 8'h00);
    fill_d   = (hit && !OVERLAP) ? 4'd0 : fill_inc;
    cnt_d    = cnt_q;
    if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    idx_dec  = idx_q - IDX_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      pat_q   <= 8'b0000_1011;
      len_q   <= 3'd3;
      hist_q  <= '0;
      fill_q  <= '0;
      x_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      z_q    <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CFG_WE) begin
            pat_q <= CFG_PAT;
            len_q <= CFG_LEN;
          end
          if (handshake) begin
            word_q  <= IN_DATA;
            last_q  <= IN_LAST;
            idx_q   <= IDX_W'(WORD_W - 1);
            x_q     <= IN_DATA[WORD_W-1];
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          hist_q <= hist_d[6:0];
          fill_q <= fill_d;
          z_q    <= hit;
          cnt_q  <= cnt_d;
          if (idx_q == '0) begin
            x_q     <= 1'b0;
            state_q <= last_q ? S_FLUSH : S_WAIT;
          end else begin
            idx_q <= idx_dec;
            x_q   <= word_q[idx_dec];
          end
        end
        S_WAIT: begin
          // Continuation word: detector history and count carry over.
          if (handshake) begin
            word_q  <= IN_DATA;
            last_q  <= IN_LAST;
            idx_q   <= IDX_W'(WORD_W - 1);
            x_q     <= IN_DATA[WORD_W-1];
            state_q <= S_SHIFT;
          end
        end
        S_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign X_OUT     = x_q;
  assign Z         = z_q;
  assign MATCH_CNT = cnt_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus pushes expected bits/counts from a stream-level model,
// a negedge monitor pops and compares. A second instance with CNT_W=2 exercises counter saturation.
module tb_seq_detect_ctrl;
  localparam int W = 8;

`ifdef SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         r = 1'b1;
  logic         cfg_we = 1'b0;
  logic [7:0]   cfg_pat = '0;
  logic [2:0]   cfg_len = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;

  logic       in_ready_a, x_a, z_a, busy_a, done_a;
  logic [7:0] cnt_a;
  logic       in_ready_b, x_b, z_b, busy_b, done_b;
  logic [1:0] cnt_b;

  seq_detect_ctrl #(.WORD_W(W), .CNT_W(8)) dut_a (
    .CLK(clk), .R(r), .CFG_WE(cfg_we), .CFG_PAT(cfg_pat), .CFG_LEN(cfg_len),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_LAST(in_last), .IN_READY(in_ready_a),
    .X_OUT(x_a), .Z(z_a), .MATCH_CNT(cnt_a), .BUSY(busy_a), .DONE(done_a)
  );

  seq_detect_ctrl #(.WORD_W(W), .CNT_W(2)) dut_b (
    .CLK(clk), .R(r), .CFG_WE(cfg_we), .CFG_PAT(cfg_pat), .CFG_LEN(cfg_len),
    .IN_VALID(in_valid), .IN_DATA(in_data), .IN_LAST(in_last), .IN_READY(in_ready_b),
    .X_OUT(x_b), .Z(z_b), .MATCH_CNT(cnt_b), .BUSY(busy_b), .DONE(done_b)
  );

  typedef struct {
    bit x;
    bit z;
    int cnt;
  } bit_exp_t;

  bit_exp_t     exp_bits[$];
  int           exp_done[$];
  logic [W-1:0] fw[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/empty expected event at %0t", name, $time);
  endtask

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  // Reference model: the frame's bit stream as a list, matching by direct look-back.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_hist[$];
  int         m_fresh;
  int         m_cnt;

  function automatic void model_cfg(input logic [7:0] p, input logic [2:0] l);
    m_pat = p;
    m_len = int'(l) + 1;
  endfunction

  function automatic void model_start();
    m_hist.delete();
    m_fresh = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_word(input logic [W-1:0] d, input bit last);
    for (int j = W - 1; j >= 0; j--) begin
      bit b;
      bit hit;
      b = d[j];
      m_hist.push_back(b);
      m_fresh++;
      hit = (m_fresh >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (hit && (m_hist[m_hist.size() - 1 - i] != m_pat[i])) hit = 1'b0;
      end
      if (hit) begin
        m_cnt++;
        if (!OVERLAP) m_fresh = 0;
      end
      exp_bits.push_back('{x: b, z: hit, cnt: m_cnt});
    end
    if (last) exp_done.push_back(m_cnt);
  endfunction

  // Monitor
  int shift_left = 0;
  int done_cnt   = -1;
  bit pend_v     = 1'b0;
  bit pend_z     = 1'b0;
  int pend_cnt   = 0;
  bit after_rst  = 1'b0;
  bit idle_chk   = 1'b0;

  always @(negedge clk) begin
    if (r) begin
      check("ready_in_reset", 32'(in_ready_a), 32'(0));
      shift_left = 0;
      done_cnt   = -1;
      pend_v     = 1'b0;
      idle_chk   = 1'b0;
      after_rst  = 1'b1;
    end else begin
      if (after_rst) begin
        check("rst_cnt_a", 32'(cnt_a), 32'(0));
        check("rst_cnt_b", 32'(cnt_b), 32'(0));
        check("rst_z", 32'(z_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_ready", 32'(in_ready_a), 32'(1));
        after_rst = 1'b0;
      end
      check("z_a", 32'(z_a), 32'(pend_v && pend_z));
      check("z_b", 32'(z_b), 32'(pend_v && pend_z));
      if (pend_v) begin
        check("cnt_a", 32'(cnt_a), 32'(sat(pend_cnt, 255)));
        check("cnt_b", 32'(cnt_b), 32'(sat(pend_cnt, 3)));
        pend_v = 1'b0;
      end
      if (idle_chk) begin
        check("idle_ready", 32'(in_ready_a), 32'(1));
        check("idle_busy", 32'(busy_a), 32'(0));
        idle_chk = 1'b0;
      end
      if (shift_left > 0) begin
        if (exp_bits.size() == 0) begin
          fail_now("bit_queue_empty");
        end else begin
          bit_exp_t e;
          e = exp_bits.pop_front();
          check("x_a", 32'(x_a), 32'(e.x));
          check("x_b", 32'(x_b), 32'(e.x));
          pend_v   = 1'b1;
          pend_z   = e.z;
          pend_cnt = e.cnt;
        end
        check("ready_shift", 32'(in_ready_a), 32'(0));
        check("busy_shift", 32'(busy_a), 32'(1));
        shift_left--;
      end
      if (done_cnt > 0) done_cnt--;
      check("done_a", 32'(done_a), 32'(done_cnt == 0));
      check("done_b", 32'(done_b), 32'(done_cnt == 0));
      if (done_cnt == 1) check("ready_flush", 32'(in_ready_a), 32'(0));
      if (done_cnt == 0) begin
        if (exp_done.size() == 0) begin
          fail_now("done_queue_empty");
        end else begin
          int c;
          c = exp_done.pop_front();
          check("final_cnt_a", 32'(cnt_a), 32'(sat(c, 255)));
          check("final_cnt_b", 32'(cnt_b), 32'(sat(c, 3)));
          $display("frame done: MATCH_CNT a=%0d b=%0d expected %0d", cnt_a, cnt_b, c);
        end
        check("ready_done", 32'(in_ready_a), 32'(0));
        done_cnt = -1;
        idle_chk = 1'b1;
      end
      if (in_valid && in_ready_a) begin
        shift_left = W;
        if (in_last) done_cnt = W + 2;
      end
    end
  end

  // Stimulus
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_a && !busy_a) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output time t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_a) ok = 1'b1;
    end
    if (!ok) begin
      fail_now("accept_timeout");
    end else begin
      @(posedge clk);
      t = $time;
      #1;
    end
  endtask

  // mode: 0 keep pattern, 1 configure in the IDLE cycle before, 2 configure with the first handshake
  task automatic run_frame(input int mode, input logic [7:0] p, input logic [2:0] l,
                           input bit hold, input int max_gap, input bit junk);
    time t;
    time prev_t;
    bit  ok;
    prev_t = 0;
    wait_idle();
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_pat = p; cfg_len = l;
      model_cfg(p, l);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
    end
    model_start();
    for (int i = 0; i < fw.size(); i++) begin
      bit last;
      last = (i == fw.size() - 1);
      if (i > 0 && !hold) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
          in_data = W'($urandom);
          in_last = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
      if (mode == 2 && i == 0) begin
        cfg_we = 1'b1; cfg_pat = p; cfg_len = l;
        model_cfg(p, l);
      end
      model_word(fw[i], last);
      in_valid = 1'b1; in_data = fw[i]; in_last = last;
      wait_accept(t, ok);
      if (!ok) return;
      $display("word accepted: data=%02h last=%0d at %0t", fw[i], last, t);
      cfg_we = 1'b0;
      if (hold && i > 0) check("accept_spacing", 32'(t - prev_t), 32'((W + 1) * 10));
      prev_t = t;
      if (!hold) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end
      if (junk) begin
        cfg_we = 1'b1; cfg_pat = 8'($urandom); cfg_len = 3'($urandom);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic reset_mid_frame();
    time t;
    bit  ok;
    wait_idle();
    cfg_we = 1'b1; cfg_pat = 8'h3C; cfg_len = 3'd5;
    model_cfg(8'h3C, 3'd5);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    model_start();
    model_word(8'hA5, 1'b1);
    in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1;
    wait_accept(t, ok);
    if (!ok) return;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    r = 1'b1;
    exp_bits.delete();
    exp_done.delete();
    model_cfg(8'h0B, 3'd3);
    $display("reset asserted mid-frame at %0t", $time);
    @(posedge clk);
    #1;
    r = 1'b0;
  endtask

  initial begin
    model_cfg(8'h0B, 3'd3);
    repeat (3) @(posedge clk);
    #1;
    r = 1'b0;

    fw = '{8'h5B};
    run_frame(0, 8'h00, 3'd0, 1'b0, 0, 1'b0);
    fw = '{8'h01, 8'h60};
    run_frame(0, 8'h00, 3'd0, 1'b0, 4, 1'b0);
    fw = '{8'hFF, 8'hFF};
    run_frame(1, 8'hFF, 3'd7, 1'b0, 3, 1'b1);
    fw = '{8'h6D, 8'hB6, 8'hDB};
    run_frame(2, 8'h05, 3'd2, 1'b1, 0, 1'b0);
    fw = '{8'hA6, 8'h9A, 8'h69};
    run_frame(0, 8'h00, 3'd0, 1'b0, 14, 1'b1);
    reset_mid_frame();
    fw = '{8'h5B};
    run_frame(0, 8'h00, 3'd0, 1'b0, 0, 1'b0);
    fw = '{8'hFF};
    run_frame(2, 8'h01, 3'd0, 1'b0, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      fw.delete();
      for (int i = 0; i < nw; i++) fw.push_back(W'($urandom));
      run_frame($urandom_range(0, 2), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3)),
                1'($urandom), $urandom_range(0, 12), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("bits_left", 32'(exp_bits.size()), 32'(0));
    check("frames_left", 32'(exp_done.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Frame-level controller for the serial Moore sequence detector path. It accepts parallel words over a valid/ready handshake and serializes each one MSB-first. It detects a programmable 1–8-bit pattern in the resulting bit stream, with history carried across word boundaries within a frame. It counts matches per frame and signals frame completion, so the detector can be shared by a word-oriented producer without bit-level sequencing.

## Interface
- WORD_W, 8, input word width (2..16)
- CNT_W, 8, match counter width; counter saturates
- CLK  in  1  clock, all logic on posedge
- R  in  1  reset, synchronous, active-high
- CFG_WE  in  1  load CFG_PAT/CFG_LEN; honored only in IDLE
- CFG_PAT  in  8  pattern; bit 0 = most recent bit of the stream
- CFG_LEN  in  3  pattern length minus 1 (0 → 1 bit, 7 → 8 bits)
- IN_VALID  in  1  word offered
- IN_DATA  in  WORD_W  word, serialized MSB first
- IN_LAST  in  1  word is last of frame; qualified by IN_VALID
- IN_READY  out  1  controller accepts word this cycle
- X_OUT  out  1  serial bit currently presented (valid while BUSY in SHIFT)
- Z  out  1  match flag, Moore-registered, one cycle per match
- MATCH_CNT  out  CNT_W  matches in current frame
- BUSY  out  1  state is not IDLE
- DONE  out  1  one-cycle pulse at frame end; MATCH_CNT final in that cycle

## Operation
- States: IDLE, SHIFT, WAIT, FLUSH, DONE.
- Reset (R high at an edge): state←IDLE, pattern←4'b1011, len←3, history←0, fill←0, bit index←0, Z/X_OUT/DONE/MATCH_CNT←0. IN_READY forced 0 while R high.
- IDLE: IN_READY=1. A handshake (IN_VALID&IN_READY) latches word and last flag, clears history, fill, and MATCH_CNT, and goes to SHIFT with bit index WORD_W-1.
- CFG_WE in IDLE latches the pattern. If it coincides with a handshake, the new pattern applies to that frame.
- SHIFT: X_OUT = word[index]. At each edge, history←{history[6:0],X_OUT} and fill←min(fill+1,8). The index decrements. After index 0, go to WAIT if last=0 or FLUSH if last=1.
- WAIT: IN_READY=1. A handshake latches the next word and returns to SHIFT. History, fill, and MATCH_CNT are kept. Without a handshake, stay in WAIT.
- FLUSH: one cycle, so that Z/MATCH_CNT for the final bit are visible. Then go to DONE.
- DONE: DONE=1 for one cycle, then go to IDLE. MATCH_CNT holds until the next frame starts.
- Match condition, evaluated on the updated history at the shift edge: fill ≥ len+1 and the low len+1 bits of history equal the low len+1 bits of the pattern.
- On a match, Z←1 and MATCH_CNT←MATCH_CNT+1, saturating at 2^CNT_W−1. Otherwise Z←0.
- Z and MATCH_CNT change only on shift edges and at frame start. Z←0 on any non-shift edge.
- IN_DATA and IN_LAST are ignored outside a handshake.

## Timing
- Word accepted at edge k: its bits appear on X_OUT in cycles k+1..k+WORD_W.
- Bit presented in cycle n: the Z for that bit is high in cycle n+1.
- Throughput: WORD_W+1 cycles per word when IN_VALID is held high (one WAIT cycle between words).
- Last word accepted at edge k: FLUSH in cycle k+WORD_W+1, DONE in cycle k+WORD_W+2, IDLE/IN_READY in cycle k+WORD_W+3.
- R mid-frame: at the next edge all state returns to reset values and the partial frame is discarded with no DONE.

## Configuration
- SEQ_OVERLAP_EN defined: history and fill are kept after a match, so overlapping matches count. Stream 1011011 gives 2 matches.
- SEQ_OVERLAP_EN undefined: fill←0 on the match edge, so a new match needs len+1 fresh bits. Stream 1011011 gives 1 match.
- Interface and timing are identical in both builds.

## Test plan
- Reset pattern, single frame 0x5B with IN_LAST=1:
  - With SEQ_OVERLAP_EN: Z high in cycles k+6 and k+9, MATCH_CNT=2 at DONE (cycle k+10).
  - Without SEQ_OVERLAP_EN: only the k+6 pulse, MATCH_CNT=1.
- Cross-word history: frame 0x01, 0x60 (second word marked last) → exactly one Z, on the third bit of the second word; MATCH_CNT=1.
- Reconfiguration: CFG_PAT=0xFF, CFG_LEN=7, then frame 0xFF, 0xFF:
  - With SEQ_OVERLAP_EN: MATCH_CNT=9.
  - Without SEQ_OVERLAP_EN: MATCH_CNT=2.
  - A CFG_WE pulse during SHIFT has no effect.
- Handshake: IN_VALID held high across 3 words → IN_READY high only in IDLE/WAIT. Consecutive accepts are WORD_W+1 cycles apart. Withholding IN_VALID in WAIT holds the state with history intact.
- Reset mid-frame: R asserted in the 4th SHIFT cycle → next cycle IDLE, MATCH_CNT=0, Z=0, no DONE, pattern back to 1011.
- Saturation: CNT_W=2, 1-bit pattern "1", frame of one 0xFF word → MATCH_CNT stops at 3.
